// File: rtl/uart_bus_slave_pkg.sv
// rtl/uart_bus_slave_pkg.sv - register offsets, status bit indices and FSM encodings for uart_bus_slave
package uart_bus_slave_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;
    localparam logic [1:0] UART_RXDATA = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_TX_BUSY  = 2;
    localparam int ST_TX_OVF   = 3;
    localparam int ST_RX_VALID = 4;
    localparam int ST_RX_OVR   = 5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO with extra-MSB pointers for full/empty
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_bus_slave.sv
// rtl/uart_bus_slave.sv - memory-mapped 8N1 UART with TX FIFO; RX path built only with UART_RX_EN
module uart_bus_slave
    import uart_bus_slave_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter int unsigned DIV_RESET  = 433,
    parameter int          DIV_BITS   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r_en,
    input  logic [31:0] r_addr,
    output logic [31:0] r_data,
    input  logic        w_en,
    input  logic [31:0] w_addr,
    input  logic [31:0] w_data,
    input  logic [3:0]  w_strb,
    output logic        uart_tx,
    input  logic        uart_rx
);

    logic [DIV_BITS-1:0] div;
    logic                tx_ovf;
    logic                rx_valid;
    logic                rx_ovr;
    logic [7:0]          rx_byte;

    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    tx_state_t           tx_state, tx_state_next;
    logic [DIV_BITS-1:0] bit_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          tx_shift;
    logic                tx_line;
    logic                bit_end;

    logic        wr_div, wr_status;
    logic [31:0] strb_mask;
    logic [31:0] status_word;
    logic [31:0] rd_mux;

    assign fifo_push = w_en && (w_addr[3:2] == UART_TXDATA) && w_strb[0];
    assign wr_div    = w_en && (w_addr[3:2] == UART_DIV);
    assign wr_status = w_en && (w_addr[3:2] == UART_STATUS) && w_strb[0];
    assign strb_mask = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (w_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bit_end = (bit_cnt == '0);

    always_comb begin
        tx_state_next = tx_state;
        fifo_pop      = 1'b0;
        tx_line       = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                tx_line = 1'b0;
                if (bit_end) tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                tx_line = tx_shift[bit_idx];
                if (bit_end && bit_idx == 3'd7) tx_state_next = TX_STOP;
            end
            TX_STOP: begin
                if (bit_end) begin
                    // back-to-back frames go straight into the next start bit
                    if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        tx_state_next = TX_START;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            uart_tx  <= tx_line;
            if (fifo_pop) begin
                tx_shift <= fifo_dout;
                bit_idx  <= '0;
            end else if (tx_state == TX_DATA && bit_end) begin
                bit_idx <= bit_idx + 3'd1;
            end
            // reload only at bit boundaries so a DIV write never stretches the current bit
            if (fifo_pop || (tx_state != TX_IDLE && bit_end)) begin
                bit_cnt <= div;
            end else if (tx_state != TX_IDLE) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div    <= DIV_BITS'(DIV_RESET);
            tx_ovf <= 1'b0;
            r_data <= '0;
        end else begin
            if (wr_div) begin
                div <= (div & ~strb_mask[DIV_BITS-1:0]) | (w_data[DIV_BITS-1:0] & strb_mask[DIV_BITS-1:0]);
            end
            if (fifo_push && fifo_full) begin
                tx_ovf <= 1'b1;
            end else if (wr_status && w_data[ST_TX_OVF]) begin
                tx_ovf <= 1'b0;
            end
            if (r_en) begin
                r_data <= rd_mux;
            end
        end
    end

    always_comb begin
        status_word              = '0;
        status_word[ST_TX_FULL]  = fifo_full;
        status_word[ST_TX_EMPTY] = fifo_empty && (tx_state == TX_IDLE);
        status_word[ST_TX_BUSY]  = (tx_state != TX_IDLE);
        status_word[ST_TX_OVF]   = tx_ovf;
        status_word[ST_RX_VALID] = rx_valid;
        status_word[ST_RX_OVR]   = rx_ovr;
    end

    always_comb begin
        rd_mux = '0;
        case (r_addr[3:2])
            UART_STATUS: rd_mux = status_word;
            UART_DIV:    rd_mux = 32'(div);
            UART_RXDATA: rd_mux = {24'b0, rx_byte};
            default:     rd_mux = '0;
        endcase
    end

`ifdef UART_RX_EN
    logic                rx_s1, rx_s2, rx_prev;
    rx_state_t           rx_state, rx_state_next;
    logic [DIV_BITS-1:0] rx_cnt;
    logic [2:0]          rx_idx;
    logic [7:0]          rx_shift;
    logic                rx_done;
    logic                rd_rxdata;

    assign rd_rxdata = r_en && (r_addr[3:2] == UART_RXDATA);

    always_comb begin
        rx_state_next = rx_state;
        rx_done       = 1'b0;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s2) rx_state_next = RX_START;
            RX_START: if (rx_cnt == '0) rx_state_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt == '0 && rx_idx == 3'd7) rx_state_next = RX_STOP;
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_next = RX_IDLE;
                    rx_done       = rx_s2;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_next;
            if (rx_state == RX_IDLE) begin
                // half a bit period puts the first sample near the middle of the start bit
                rx_cnt <= div >> 1;
                rx_idx <= '0;
            end else if (rx_cnt == '0) begin
                rx_cnt <= div;
                if (rx_state == RX_DATA) begin
                    rx_shift[rx_idx] <= rx_s2;
                    rx_idx           <= rx_idx + 3'd1;
                end
            end else begin
                rx_cnt <= rx_cnt - 1'b1;
            end
            if (rx_done) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rd_rxdata) rx_ovr <= 1'b1;
            end else begin
                if (rd_rxdata) rx_valid <= 1'b0;
                if (wr_status && w_data[ST_RX_OVR]) rx_ovr <= 1'b0;
            end
        end
    end
`else
    assign rx_valid = 1'b0;
    assign rx_ovr   = 1'b0;
    assign rx_byte  = 8'h00;
`endif

    logic unused;
    assign unused = ^{r_addr[31:4], r_addr[1:0], w_addr[31:4], w_addr[1:0], w_data, strb_mask, uart_rx};

endmodule
